// File: rtl/npc_fetch_if.sv
// npc_fetch_if: instruction-memory fetch handshake plus the fetch-to-decode
// instruction handshake of the ToyMips front end.
//   master : the fetch unit (drives the request and the latched instruction)
//   slave  : memory / decode side (drives ready, response data, instr_ready)
interface npc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr_out, instr_valid,
    input  imem_ready, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_out, instr_valid,
    output imem_ready, imem_rvalid, imem_rdata, instr_ready
  );
endinterface

// File: rtl/npc_fetch.sv
// npc_fetch: program counter, instruction fetch and next-PC sequencer.
// Sequence per instruction: REQ (address out) -> WAIT (response) -> HOLD
// (instruction shown to decode) -> PC update on instr_ready.
// Optional feature macro NPC_ALIGN_CHECK_EN: a JR to a non-word-aligned
// target freezes the PC, raises a sticky addr_err and parks in ERR until
// reset. Without it, JR simply drops rs_val[1:0].
module npc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   npc_op,
  input  logic         if_branch,
  input  logic         zero,
  input  logic [31:0]  rs_val,
  npc_fetch_if.master  bus,
  output logic [31:0]  pc_out,
  output logic [31:0]  link_pc
`ifdef NPC_ALIGN_CHECK_EN
  ,
  output logic         addr_err
`endif
);

  localparam logic [3:0] OP_JUMP = 4'b0000;
  localparam logic [3:0] OP_JAL  = 4'b0001;
  localparam logic [3:0] OP_BEQ  = 4'b0010;
  localparam logic [3:0] OP_BNE  = 4'b0011;
  localparam logic [3:0] OP_BGEZ = 4'b0100;
  localparam logic [3:0] OP_BGTZ = 4'b0101;
  localparam logic [3:0] OP_BLEZ = 4'b0110;
  localparam logic [3:0] OP_BLTZ = 4'b0111;
  localparam logic [3:0] OP_JR   = 4'b1000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3
`ifdef NPC_ALIGN_CHECK_EN
    ,
    ERR  = 3'd4
`endif
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] p4;
  logic [31:0] br_off;
  logic [31:0] br_target;
  logic        br_taken;
  logic [31:0] next_pc;
  logic        rs_is_zero;
`ifdef NPC_ALIGN_CHECK_EN
  logic        addr_err_reg, addr_err_next;
  logic        jr_misaligned;
`endif

  assign p4         = pc_reg + 32'd4;
  assign rs_is_zero = (rs_val == 32'd0);
  // Branch offset is sign-extended imm16, optionally scaled to words.
  assign br_off     = if_branch ? {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00}
                                : {{16{instr_reg[15]}}, instr_reg[15:0]};
  assign br_target  = p4 + br_off;

  // Next-PC selection from the decoder's jump/branch type and branch condition.
  always_comb begin
    br_taken = 1'b0;
    next_pc  = p4;
    case (npc_op)
      OP_BEQ:  br_taken = zero;
      OP_BNE:  br_taken = !zero;
      OP_BGEZ: br_taken = !rs_val[31];
      OP_BGTZ: br_taken = !rs_val[31] && !rs_is_zero;
      OP_BLEZ: br_taken = rs_val[31] || rs_is_zero;
      OP_BLTZ: br_taken = rs_val[31];
      default: br_taken = 1'b0;
    endcase
    case (npc_op)
      OP_JUMP, OP_JAL: next_pc = {p4[31:28], instr_reg[25:0], 2'b00};
      OP_BEQ, OP_BNE, OP_BGEZ, OP_BGTZ,
      OP_BLEZ, OP_BLTZ: next_pc = br_taken ? br_target : p4;
      OP_JR:           next_pc = {rs_val[31:2], 2'b00};
      default:         next_pc = p4;   // ADD4 and every unassigned code
    endcase
  end

`ifdef NPC_ALIGN_CHECK_EN
  assign jr_misaligned = (npc_op == OP_JR) && (rs_val[1:0] != 2'b00);
`endif

  // Fetch FSM next state, instruction latch and PC commit.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
`ifdef NPC_ALIGN_CHECK_EN
    addr_err_next = addr_err_reg;
`endif
    case (state_reg)
      IDLE: state_next = REQ;
      REQ:  if (bus.imem_ready) state_next = WAIT;
      WAIT: begin
        if (bus.imem_rvalid) begin
          instr_next = bus.imem_rdata;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (bus.instr_ready) begin
`ifdef NPC_ALIGN_CHECK_EN
          if (jr_misaligned) begin
            addr_err_next = 1'b1;
            state_next    = ERR;
          end else begin
            pc_next    = next_pc;
            state_next = REQ;
          end
`else
          pc_next    = next_pc;
          state_next = REQ;
`endif
        end
      end
`ifdef NPC_ALIGN_CHECK_EN
      ERR:  state_next = ERR;
`endif
      default: state_next = IDLE;
    endcase
  end

  // State, PC and instruction registers; reset drops any in-flight fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      instr_reg <= 32'd0;
`ifdef NPC_ALIGN_CHECK_EN
      addr_err_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
`ifdef NPC_ALIGN_CHECK_EN
      addr_err_reg <= addr_err_next;
`endif
    end
  end

  assign bus.imem_req    = (state_reg == REQ);
  assign bus.imem_addr   = pc_reg;
  assign bus.instr_out   = instr_reg;
  assign bus.instr_valid = (state_reg == HOLD);
  assign pc_out          = pc_reg;
  assign link_pc         = p4;
`ifdef NPC_ALIGN_CHECK_EN
  assign addr_err        = addr_err_reg;
`endif

endmodule
